regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; successor to the CPU's 16x32 two-read-port register file.
- Adds configurable width, depth and read-port count, plus clean half-word write modes (FULL / HI / LO).
- Adds a per-register pending scoreboard for the issue stage, so decode can detect RAW hazards on registers with an in-flight producer.
- Sits between decode (reads, reserve) and writeback (writes).

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/rf_write_merge.sv | 41 ++++
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the multi-port register file.
//   wr_mode_t   : write-mode encoding (FULL / HI / LO / reserved)
//   DEF_*       : default geometry of the register file
//   popcount_w  : population count, used by the pending-count assertion
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [1:0] {
        WM_FULL = 2'd0,
        WM_HI   = 2'd1,
        WM_LO   = 2'd2,
        WM_RSVD = 2'd3
    } wr_mode_t;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_NUM_RD   = 2;

    // Widest pending vector popcount_w can take; narrower vectors are zero-extended.
    localparam int unsigned POP_MAX_W = 1024;

    function automatic int unsigned popcount_w(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_write_merge.sv
// -----------------------------------------------------------------------------
// rf_write_merge
// Combinational merge of write data into an existing register value.
// Shared by the array write path and the write-to-read bypass path so both
// always agree on the value a register will hold after the edge.
// Ports:
//   i_old     in  DATA_W  current register contents
//   i_data    in  DATA_W  write data (HI/LO use only the low half)
//   i_mode    in  2       write mode (wr_mode_t encoding)
//   o_merged  out DATA_W  value after the write
//   o_legal   out 1       0 for the reserved mode
// -----------------------------------------------------------------------------
module rf_write_merge
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_merged,
    output logic              o_legal
);

    localparam int unsigned HALF = DATA_W / 2;

    wr_mode_t w_mode;
    assign w_mode = wr_mode_t'(i_mode);

    always_comb begin
        o_merged = i_old;
        o_legal  = 1'b1;
        unique case (w_mode)
            WM_FULL: o_merged = i_data;
            WM_HI:   o_merged = {i_data[HALF-1:0], i_old[HALF-1:0]};
            WM_LO:   o_merged = {i_old[DATA_W-1:HALF], i_data[HALF-1:0]};
            WM_RSVD: o_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-read-port register file with half-word write modes and a
// per-register pending scoreboard for RAW hazard detection at issue.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk       in  1                 clock, rising edge
//   rst       in  1                 synchronous reset, active-high
//   rd_addr   in  NUM_RD*AW         read addresses, port i at [i*AW +: AW]
//   rd_data   out NUM_RD*DATA_W     read data, port i at [i*DATA_W +: DATA_W]
//   rd_pend   out NUM_RD            addressed register has a reservation
//   wr        in  1                 write enable
//   wr_dst    in  AW                write address
//   wr_mode   in  2                 0 FULL, 1 HI, 2 LO, 3 reserved
//   wr_data   in  DATA_W            write data
//   rsv       in  1                 reserve request
//   rsv_dst   in  AW                register to mark pending
//   pend_cnt  out $clog2(NUM_REGS+1) number of pending registers
//   wr_err    out 1                 one-cycle pulse after a reserved-mode write
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter bit          R0_ZERO  = 1'b1,
    localparam int unsigned AW      = $clog2(NUM_REGS),
    localparam int unsigned CW      = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wr,
    input  logic [AW-1:0]            wr_dst,
    input  logic [1:0]               wr_mode,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv,
    input  logic [AW-1:0]            rsv_dst,
    output logic [CW-1:0]            pend_cnt,
    output logic                     wr_err
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [CW-1:0]       r_pend_cnt;
    logic                r_wr_err;

    logic [DATA_W-1:0]   w_merged;
    logic                w_legal;
    logic                w_wr_r0;
    logic                w_rsv_r0;
    logic                w_wr_ok;
    logic                w_rsv_ok;
    logic                w_set;
    logic                w_clr;

    rf_write_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .i_old    (r_regs[wr_dst]),
        .i_data   (wr_data),
        .i_mode   (wr_mode),
        .o_merged (w_merged),
        .o_legal  (w_legal)
    );

    assign w_wr_r0  = R0_ZERO && (wr_dst == '0);
    assign w_rsv_r0 = R0_ZERO && (rsv_dst == '0);
    assign w_wr_ok  = wr && w_legal && !w_wr_r0;
    assign w_rsv_ok = rsv && !w_rsv_r0;

    // Count tracks bit transitions, not requests: reserving an already pending
    // register sets nothing, and a write racing a reserve to the same register
    // clears nothing because the reserve wins.
    assign w_set = w_rsv_ok && !r_pend[rsv_dst];
    assign w_clr = w_wr_ok && r_pend[wr_dst] && !(w_rsv_ok && (rsv_dst == wr_dst));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_dst] <= w_merged;
                r_pend[wr_dst] <= 1'b0;
            end
            // Issued after the clear so a same-register reserve wins.
            if (w_rsv_ok) begin
                r_pend[rsv_dst] <= 1'b1;
            end
            r_pend_cnt <= r_pend_cnt + CW'(w_set) - CW'(w_clr);
            r_wr_err   <= wr && !w_legal && !w_wr_r0;
        end
    end

    assign pend_cnt = r_pend_cnt;
    assign wr_err   = r_wr_err;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_pend_bit;

        assign w_addr = rd_addr[gi*AW +: AW];

        always_comb begin
            w_data     = r_regs[w_addr];
            w_pend_bit = r_pend[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (w_addr == wr_dst)) begin
                w_data     = w_merged;
                w_pend_bit = w_rsv_ok && (rsv_dst == wr_dst);
            end
`endif
            if (R0_ZERO && (w_addr == '0)) begin
                w_data     = '0;
                w_pend_bit = 1'b0;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = w_data;
        assign rd_pend[gi]                  = w_pend_bit;
    end

    logic [POP_MAX_W-1:0] w_pend_ext;
    always_comb begin
        w_pend_ext                 = '0;
        w_pend_ext[NUM_REGS-1:0]   = r_pend;
    end

    a_pend_cnt: assert property (@(posedge clk) disable iff (rst)
        ({{(32-CW){1'b0}}, r_pend_cnt} == popcount_w(w_pend_ext)));

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int NP = 3;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_pend;
    logic              wr;
    logic [AW-1:0]     wr_dst;
    logic [1:0]        wr_mode;
    logic [DW-1:0]     wr_data;
    logic              rsv;
    logic [AW-1:0]     rsv_dst;
    logic [4:0]        pend_cnt;
    logic              wr_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];
    bit            m_err;

    regfile_mp #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NP),
        .R0_ZERO  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend),
        .wr       (wr),
        .wr_dst   (wr_dst),
        .wr_mode  (wr_mode),
        .wr_data  (wr_data),
        .rsv      (rsv),
        .rsv_dst  (rsv_dst),
        .pend_cnt (pend_cnt),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] m_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                              input logic [1:0] mode);
        case (mode)
            2'd0:    return d;
            2'd1:    return {d[15:0], old[15:0]};
            2'd2:    return {old[31:16], d[15:0]};
            default: return old;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr && wr_mode != 2'd3 && int'(wr_dst) == a) return m_merge(m_regs[a], wr_data, wr_mode);
`endif
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr && wr_mode != 2'd3 && int'(wr_dst) == a) return rsv && int'(rsv_dst) == a;
`endif
        return m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic idle();
        rst = 1'b0; wr = 1'b0; rsv = 1'b0;
        wr_dst = '0; wr_mode = '0; wr_data = '0; rsv_dst = '0;
    endtask

    task automatic set_all_rd(input int a);
        for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // Apply the rules for this edge to the model, then move to the next falling edge.
    task automatic commit();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
            m_err = 1'b0;
        end else begin
            m_err = wr && wr_mode == 2'd3 && wr_dst != 0;
            if (wr && wr_mode != 2'd3 && wr_dst != 0) begin
                m_regs[wr_dst] = m_merge(m_regs[wr_dst], wr_data, wr_mode);
                m_pend[wr_dst] = 1'b0;
            end
            if (rsv && rsv_dst != 0) m_pend[rsv_dst] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; set_all_rd(0);
        commit(); commit();
        rst = 1'b0;
        n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", wr_err); end
        set_all_rd(3);
        wr = 1'b1; wr_dst = 4'd3; wr_mode = 2'd0; wr_data = 32'hDEADBEEF;
        commit();
        idle();
        #1;
        n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_r3 got %h exp deadbeef", rd_data[31:0]); end
        // reset beats a concurrent write and reserve
        rst = 1'b1; wr = 1'b1; wr_dst = 4'd3; wr_data = 32'h1; rsv = 1'b1; rsv_dst = 4'd3;
        commit();
        idle();
        #1;
        for (int p = 0; p < NP; p++) begin
            n_cmp++;
            if (rd_data[p*DW +: DW] !== 32'h0 || rd_pend[p] !== 1'b0) begin
                n_bad++; $display("FAIL reset_r3 port%0d got %h/%b exp 0/0", p, rd_data[p*DW +: DW], rd_pend[p]);
            end
        end
        n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_cnt2 got %0d exp 0", pend_cnt); end
    endtask

    task automatic test_half_writes();
        logic [1:0]  modes [3] = '{2'd0, 2'd1, 2'd2};
        logic [31:0] datas [3] = '{32'h12345678, 32'h0000ABCD, 32'h00001111};
        logic [31:0] exps  [3] = '{32'h12345678, 32'hABCD5678, 32'hABCD1111};
        idle(); set_all_rd(5);
        for (int k = 0; k < 3; k++) begin
            wr = 1'b1; wr_dst = 4'd5; wr_mode = modes[k]; wr_data = datas[k];
            commit();
            idle();
            #1;
            n_cmp++;
            if (rd_data[31:0] !== exps[k]) begin
                n_bad++; $display("FAIL half_write step%0d got %h exp %h", k, rd_data[31:0], exps[k]);
            end
        end
    endtask

    task automatic test_r0_illegal();
        logic [31:0] v;
        idle(); set_all_rd(0);
        wr = 1'b1; wr_dst = 4'd0; wr_mode = 2'd0; wr_data = 32'hFFFFFFFF;
        commit(); idle(); #1;
        n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL r0_read got %h exp 0", rd_data[31:0]); end
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL r0_err got %b exp 0", wr_err); end
        v = $urandom;
        set_all_rd(7);
        wr = 1'b1; wr_dst = 4'd7; wr_mode = 2'd0; wr_data = v;
        commit();
        wr = 1'b1; wr_dst = 4'd7; wr_mode = 2'd3; wr_data = ~v;
        commit(); idle(); #1;
        n_cmp++; if (rd_data[31:0] !== v) begin n_bad++; $display("FAIL illegal_keep got %h exp %h", rd_data[31:0], v); end
        n_cmp++; if (wr_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got %b exp 1", wr_err); end
        commit();
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL illegal_err_pulse got %b exp 0", wr_err); end
        wr = 1'b1; wr_dst = 4'd0; wr_mode = 2'd3; wr_data = v;
        commit(); idle();
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL r0_illegal_err got %b exp 0", wr_err); end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr = {4'd4, 4'd9, 4'd2};
        rsv = 1'b1; rsv_dst = 4'd2; commit();
        rsv = 1'b1; rsv_dst = 4'd9; commit();
        idle(); #1;
        n_cmp++; if (pend_cnt !== 5'd2) begin n_bad++; $display("FAIL sb_cnt2 got %0d exp 2", pend_cnt); end
        n_cmp++; if (rd_pend !== 3'b011) begin n_bad++; $display("FAIL sb_pend got %b exp 011", rd_pend); end
        wr = 1'b1; wr_dst = 4'd2; wr_mode = 2'd0; wr_data = 32'hA5A5_0002;
        commit(); idle(); #1;
        n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL sb_cnt_clear got %0d exp 1", pend_cnt); end
        n_cmp++; if (rd_pend[0] !== 1'b0) begin n_bad++; $display("FAIL sb_pend_clear got %b exp 0", rd_pend[0]); end
        wr = 1'b1; wr_dst = 4'd9; wr_mode = 2'd0; wr_data = 32'h0000_0099;
        rsv = 1'b1; rsv_dst = 4'd9;
        commit(); idle(); #1;
        n_cmp++; if (rd_data[63:32] !== 32'h99) begin n_bad++; $display("FAIL sb_rsvwr_data got %h exp 99", rd_data[63:32]); end
        n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL sb_rsvwr_cnt got %0d exp 1", pend_cnt); end
        n_cmp++; if (rd_pend[1] !== 1'b1) begin n_bad++; $display("FAIL sb_rsvwr_pend got %b exp 1", rd_pend[1]); end
        rsv = 1'b1; rsv_dst = 4'd0;
        commit(); idle();
        n_cmp++; if (pend_cnt !== 5'd1) begin n_bad++; $display("FAIL sb_rsv_r0 got %0d exp 1", pend_cnt); end
        wr = 1'b1; wr_dst = 4'd9; wr_mode = 2'd2; wr_data = 32'h1;
        commit(); idle();
        n_cmp++; if (pend_cnt !== 5'd0) begin n_bad++; $display("FAIL sb_drain got %0d exp 0", pend_cnt); end
    endtask

    task automatic test_port_alias();
        idle(); set_all_rd(4);
        wr = 1'b1; wr_dst = 4'd4; wr_mode = 2'd0; wr_data = 32'h55AA55AA;
        commit(); idle(); #1;
        for (int p = 0; p < NP; p++) begin
            n_cmp++;
            if (rd_data[p*DW +: DW] !== 32'h55AA55AA) begin
                n_bad++; $display("FAIL alias port%0d got %h exp 55aa55aa", p, rd_data[p*DW +: DW]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e_d;
        bit          e_p;
        idle(); set_all_rd(6);
        wr = 1'b1; wr_dst = 4'd6; wr_mode = 2'd0; wr_data = 32'h1; rsv = 1'b1; rsv_dst = 4'd6;
        commit();
        idle();
        wr = 1'b1; wr_dst = 4'd6; wr_mode = 2'd0; wr_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        e_d = 32'h2; e_p = 1'b0;
`else
        e_d = 32'h1; e_p = 1'b1;
`endif
        n_cmp++; if (rd_data[31:0] !== e_d) begin n_bad++; $display("FAIL bypass_data got %h exp %h", rd_data[31:0], e_d); end
        n_cmp++; if (rd_pend[0] !== e_p) begin n_bad++; $display("FAIL bypass_pend got %b exp %b", rd_pend[0], e_p); end
        commit(); idle(); #1;
        n_cmp++; if (rd_data[31:0] !== 32'h2) begin n_bad++; $display("FAIL bypass_next got %h exp 2", rd_data[31:0]); end
        wr = 1'b1; wr_dst = 4'd6; wr_mode = 2'd1; wr_data = 32'h00003333; rsv = 1'b1; rsv_dst = 4'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        e_d = 32'h33330002; e_p = 1'b1;
`else
        e_d = 32'h2; e_p = 1'b0;
`endif
        n_cmp++; if (rd_data[95:64] !== e_d) begin n_bad++; $display("FAIL bypass_hi_data got %h exp %h", rd_data[95:64], e_d); end
        n_cmp++; if (rd_pend[2] !== e_p) begin n_bad++; $display("FAIL bypass_hi_pend got %b exp %b", rd_pend[2], e_p); end
        commit(); idle();
        wr = 1'b1; wr_dst = 4'd6; wr_mode = 2'd0; wr_data = 32'h0;
        commit(); idle();
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            rst     = ($urandom_range(0, 59) == 0);
            wr      = $urandom_range(0, 1) == 1;
            wr_dst  = AW'($urandom_range(0, NR-1));
            wr_mode = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            rsv     = $urandom_range(0, 2) == 0;
            rsv_dst = ($urandom_range(0, 3) == 0) ? wr_dst : AW'($urandom_range(0, NR-1));
            rd_addr = NP*AW'($urandom);
            if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wr_dst;
            #1;
            if (!rst) begin
                for (int p = 0; p < NP; p++) begin
                    int a;
                    a = int'(rd_addr[p*AW +: AW]);
                    n_cmp++;
                    if (rd_data[p*DW +: DW] !== exp_data(a) || rd_pend[p] !== exp_pend(a)) begin
                        n_bad++;
                        $display("FAIL rand_read it%0d port%0d r%0d got %h/%b exp %h/%b",
                                 it, p, a, rd_data[p*DW +: DW], rd_pend[p], exp_data(a), exp_pend(a));
                    end
                end
            end
            commit();
            n_cmp++;
            if (int'(pend_cnt) != exp_cnt() || wr_err !== m_err) begin
                n_bad++;
                $display("FAIL rand_state it%0d got cnt=%0d err=%b exp cnt=%0d err=%b",
                         it, pend_cnt, wr_err, exp_cnt(), m_err);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_half_writes();
        test_r0_illegal();
        test_scoreboard();
        test_port_alias();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
